// File: rtl/sa_ctrl_if.sv
// sa_ctrl_if: handshake and bus bundle for the systolic-array controller.
//   cmd_*            job request / idle handshake
//   reuse_w_i        keep array weights for this job (only with SA_CTRL_WREUSE_EN)
//   wdat_* / xdat_*  weight and activation input streams (valid/ready)
//   w_*              array weight write port
//   rbuf_*           row-buffer activation write port
//   start_vo         array start pulse
//   mac_v_i          per-column result valid from the array
//   busy_o / done_o  job active / job-complete pulse
// modport slave  : the controller side
// modport master : the host / stream source side
interface sa_ctrl_if #(
  parameter int ARRAY_W    = 8,
  parameter int ARRAY_H    = 8,
  parameter int W_W        = 8,
  parameter int X_W        = 8,
  parameter int RBUF_DEPTH = 8
);
  localparam int WA_W = $clog2(ARRAY_W*ARRAY_H);
  localparam int RA_W = $clog2(ARRAY_H) + $clog2(RBUF_DEPTH);

  logic                 cmd_v_i;
  logic                 cmd_rdy_o;
`ifdef SA_CTRL_WREUSE_EN
  logic                 reuse_w_i;
`endif
  logic                 wdat_v_i;
  logic                 wdat_rdy_o;
  logic [W_W-1:0]       wdat_i;
  logic                 xdat_v_i;
  logic                 xdat_rdy_o;
  logic [X_W-1:0]       xdat_i;
  logic [W_W-1:0]       w_o;
  logic [WA_W-1:0]      w_addr_o;
  logic                 w_en_o;
  logic [X_W-1:0]       rbuf_wdata_o;
  logic [RA_W-1:0]      rbuf_waddr_o;
  logic                 rbuf_w_vo;
  logic                 start_vo;
  logic [ARRAY_W-1:0]   mac_v_i;
  logic                 busy_o;
  logic                 done_o;

  modport slave (
    input  cmd_v_i,
`ifdef SA_CTRL_WREUSE_EN
    input  reuse_w_i,
`endif
    input  wdat_v_i, wdat_i, xdat_v_i, xdat_i, mac_v_i,
    output cmd_rdy_o, wdat_rdy_o, xdat_rdy_o,
    output w_o, w_addr_o, w_en_o,
    output rbuf_wdata_o, rbuf_waddr_o, rbuf_w_vo,
    output start_vo, busy_o, done_o
  );

  modport master (
    output cmd_v_i,
`ifdef SA_CTRL_WREUSE_EN
    output reuse_w_i,
`endif
    output wdat_v_i, wdat_i, xdat_v_i, xdat_i, mac_v_i,
    input  cmd_rdy_o, wdat_rdy_o, xdat_rdy_o,
    input  w_o, w_addr_o, w_en_o,
    input  rbuf_wdata_o, rbuf_waddr_o, rbuf_w_vo,
    input  start_vo, busy_o, done_o
  );
endinterface

// File: rtl/sa_ctrl.sv
// sa_ctrl: job sequencer for a systolic array.
// IDLE -> LOAD_W -> LOAD_X -> START -> RUN -> DONE -> IDLE.
// Streams ARRAY_W*ARRAY_H weights into the array, ARRAY_H*RBUF_DEPTH
// activations into the row buffers, fires start, then waits for
// RBUF_DEPTH+ARRAY_W-1 result-valid cycles before signalling done.
// Ports: clk_i, rst_n (async, active low), bus (sa_ctrl_if.slave).
// Optional macro SA_CTRL_WREUSE_EN: adds reuse_w_i; a job accepted with
// reuse_w_i=1 skips LOAD_W and keeps the weights already in the array.
module sa_ctrl #(
  parameter int ARRAY_W    = 8,
  parameter int ARRAY_H    = 8,
  parameter int W_W        = 8,
  parameter int X_W        = 8,
  parameter int RBUF_DEPTH = 8
) (
  input  logic     clk_i,
  input  logic     rst_n,
  sa_ctrl_if.slave bus
);
  localparam int WA_W = $clog2(ARRAY_W*ARRAY_H);
  localparam int RA_W = $clog2(ARRAY_H) + $clog2(RBUF_DEPTH);
  localparam int MC_W = $clog2(RBUF_DEPTH+ARRAY_W) + 1;
  localparam logic [WA_W-1:0] W_LAST = WA_W'(ARRAY_W*ARRAY_H-1);
  localparam logic [RA_W-1:0] X_LAST = RA_W'(ARRAY_H*RBUF_DEPTH-1);
  // transition happens on the valid cycle that brings the count to D+W-1
  localparam logic [MC_W-1:0] M_LAST = MC_W'(RBUF_DEPTH+ARRAY_W-2);

  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, START, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [WA_W-1:0] wcnt;
  logic [RA_W-1:0] xcnt;
  logic [MC_W-1:0] mcnt;
  logic cmd_acc, w_xfer, x_xfer, mac_hit;

  assign cmd_acc = (state == IDLE) && bus.cmd_v_i;
  assign w_xfer  = bus.wdat_v_i && bus.wdat_rdy_o;
  assign x_xfer  = bus.xdat_v_i && bus.xdat_rdy_o;
  assign mac_hit = (state == RUN) && (|bus.mac_v_i);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.cmd_rdy_o  = 1'b0;
    bus.wdat_rdy_o = 1'b0;
    bus.xdat_rdy_o = 1'b0;
    bus.busy_o     = 1'b1;
    bus.done_o     = 1'b0;
    case (state)
      IDLE: begin
        bus.cmd_rdy_o = 1'b1;
        bus.busy_o    = 1'b0;
        if (bus.cmd_v_i) begin
`ifdef SA_CTRL_WREUSE_EN
          state_nxt = bus.reuse_w_i ? LOAD_X : LOAD_W;
`else
          state_nxt = LOAD_W;
`endif
        end
      end
      LOAD_W: begin
        bus.wdat_rdy_o = 1'b1;
        if (bus.wdat_v_i && wcnt == W_LAST) state_nxt = LOAD_X;
      end
      LOAD_X: begin
        bus.xdat_rdy_o = 1'b1;
        if (bus.xdat_v_i && xcnt == X_LAST) state_nxt = START;
      end
      START:   state_nxt = RUN;
      RUN:     if (mac_hit && mcnt == M_LAST) state_nxt = DONE;
      DONE: begin
        bus.done_o = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered write ports: each beat appears one cycle after its transfer.
  // start_vo is registered off START so it lands the cycle after the last
  // rbuf write and never overlaps it.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      bus.w_en_o       <= 1'b0;
      bus.w_o          <= '0;
      bus.w_addr_o     <= '0;
      bus.rbuf_w_vo    <= 1'b0;
      bus.rbuf_wdata_o <= '0;
      bus.rbuf_waddr_o <= '0;
      bus.start_vo     <= 1'b0;
      wcnt             <= '0;
      xcnt             <= '0;
      mcnt             <= '0;
    end else begin
      bus.w_en_o    <= w_xfer;
      bus.rbuf_w_vo <= x_xfer;
      bus.start_vo  <= (state == START);
      if (w_xfer) begin
        bus.w_o      <= W_W'(bus.wdat_i);
        bus.w_addr_o <= wcnt;
      end
      if (x_xfer) begin
        bus.rbuf_wdata_o <= X_W'(bus.xdat_i);
        bus.rbuf_waddr_o <= xcnt;
      end
      if (cmd_acc) begin
        wcnt <= '0;
        xcnt <= '0;
        mcnt <= '0;
      end else begin
        if (w_xfer)  wcnt <= wcnt + 1'b1;
        if (x_xfer)  xcnt <= xcnt + 1'b1;
        if (mac_hit) mcnt <= mcnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sa_ctrl.sv
// tb_sa_ctrl: directed scoreboard bench for sa_ctrl.
// The stimulus pushes the expected write/start/done events as beats are
// handed over; a negedge monitor pops and compares whenever the DUT
// presents one of those outputs.
module tb_sa_ctrl;
  localparam int AW = 8, AH = 8, WW = 8, XW = 8, RD = 8;
  localparam int NW = AW*AH, NX = AH*RD, NMAC = RD+AW-1;

  logic clk_i = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk_i = ~clk_i;

  sa_ctrl_if #(.ARRAY_W(AW), .ARRAY_H(AH), .W_W(WW), .X_W(XW), .RBUF_DEPTH(RD)) bus ();
  sa_ctrl #(.ARRAY_W(AW), .ARRAY_H(AH), .W_W(WW), .X_W(XW), .RBUF_DEPTH(RD)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .bus(bus)
  );

  typedef enum logic [1:0] {EV_W, EV_X, EV_S, EV_D} ev_kind_t;
  typedef struct packed {ev_kind_t k; logic [15:0] a; logic [15:0] d;} ev_t;
  ev_t q[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int n_w = 0, n_x = 0, n_s = 0, n_d = 0, first_x_cyc = -1;

  always @(posedge clk_i) cyc++;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic sb(input ev_t got);
    ev_t e;
    if (q.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL sb_unexpected: got kind %0d addr %0d data %0h, expected no event (t=%0t)",
               got.k, got.a, got.d, $time);
    end else begin
      e = q.pop_front();
      chk("sb_kind", got.k, e.k);
      chk("sb_addr", got.a, e.a);
      chk("sb_data", got.d, e.d);
    end
  endtask

  function automatic logic [7:0] wd(input int i, input bit c);
    return c ? 8'h0F : 8'(i*7+3);
  endfunction
  function automatic logic [7:0] xd(input int i);
    return 8'(i*5+1);
  endfunction

  // monitor
  always @(negedge clk_i) begin
    if (rst_n) begin
      chk("onehot_wr_start", int'(bus.w_en_o) + int'(bus.rbuf_w_vo) + int'(bus.start_vo) <= 1, 1);
      if (bus.w_en_o) begin
        n_w++;
        sb('{k: EV_W, a: 16'(bus.w_addr_o), d: 16'(bus.w_o)});
      end
      if (bus.rbuf_w_vo) begin
        if (first_x_cyc < 0) first_x_cyc = cyc;
        n_x++;
        sb('{k: EV_X, a: 16'(bus.rbuf_waddr_o), d: 16'(bus.rbuf_wdata_o)});
      end
      if (bus.start_vo) begin n_s++; sb('{k: EV_S, a: 16'd0, d: 16'd0}); end
      if (bus.done_o)   begin n_d++; sb('{k: EV_D, a: 16'd0, d: 16'd0}); end
    end
  end

  task automatic drive(input int wi, input int xi, input int c, input bit tgl,
                       input bit wc, input bit reuse);
    logic [AW-1:0] one;
    one = 1;
    bus.wdat_v_i = (reuse || wi < NW) && (!tgl || c[0]);
    bus.wdat_i   = wd(wi, wc);
    bus.xdat_v_i = (xi < NX);
    bus.xdat_i   = xd(xi);
    // gaps every 4th cycle; nonzero before RUN as well, which must be ignored
    bus.mac_v_i  = (c % 4 == 3) ? '0 : (one << (c % AW));
  endtask

  task automatic run_job(input string nm, input bit tgl, input bit wc, input bit cmd_in_x,
                         input int abort_at, input bit reuse);
    int wi, xi, c, macs, cmd_cyc;
    bit run_seen, fin, xw, xx;
    wi = 0; xi = 0; c = 0; macs = 0; run_seen = 0; fin = 0;
    n_w = 0; n_x = 0; n_s = 0; n_d = 0; first_x_cyc = -1;
    @(posedge clk_i); #1;
    chk({nm, "_cmd_rdy"}, bus.cmd_rdy_o, 1);
    cmd_cyc = cyc;
    bus.cmd_v_i = 1'b1;
`ifdef SA_CTRL_WREUSE_EN
    bus.reuse_w_i = reuse;
`endif
    drive(wi, xi, c, tgl, wc, reuse);
    while (!fin) begin
      @(negedge clk_i);
      xw = bus.wdat_v_i && bus.wdat_rdy_o;
      xx = bus.xdat_v_i && bus.xdat_rdy_o;
      if (bus.start_vo) run_seen = 1;
      if (bus.done_o) begin
        chk({nm, "_mac_cycles"}, macs, NMAC);
        fin = 1;
      end else if (run_seen && (|bus.mac_v_i)) macs++;
      if (xw && !reuse) begin
        q.push_back('{k: EV_W, a: 16'(wi), d: 16'(wd(wi, wc))});
        wi++;
      end
      if (xx) begin
        q.push_back('{k: EV_X, a: 16'(xi), d: 16'(xd(xi))});
        xi++;
        if (xi == NX) begin
          q.push_back('{k: EV_S, a: 16'd0, d: 16'd0});
          q.push_back('{k: EV_D, a: 16'd0, d: 16'd0});
        end
      end
      @(posedge clk_i); #1;
      c++;
      bus.cmd_v_i = cmd_in_x && xi >= 10 && xi < 13;
`ifdef SA_CTRL_WREUSE_EN
      bus.reuse_w_i = 1'b0;
`endif
      if (c == 2) chk({nm, "_busy_mid"}, bus.busy_o, 1);
      if (abort_at >= 0 && wi == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk({nm, "_rst_w_en"},   bus.w_en_o, 0);
        chk({nm, "_rst_w_addr"}, bus.w_addr_o, 0);
        chk({nm, "_rst_rbuf"},   bus.rbuf_w_vo, 0);
        chk({nm, "_rst_start"},  bus.start_vo, 0);
        chk({nm, "_rst_busy"},   bus.busy_o, 0);
        chk({nm, "_rst_wrdy"},   bus.wdat_rdy_o, 0);
        chk({nm, "_rst_cmdrdy"}, bus.cmd_rdy_o, 1);
        q.delete();
        bus.wdat_v_i = 0; bus.xdat_v_i = 0; bus.mac_v_i = '0; bus.cmd_v_i = 0;
        repeat (2) @(posedge clk_i);
        #3 rst_n = 1'b1;
        return;
      end
      if (!fin) drive(wi, xi, c, tgl, wc, reuse);
      if (c > 2000) begin
        n_chk++; n_fail++;
        $display("FAIL %s_timeout: job did not finish, got %0d cycles, expected done", nm, c);
        q.delete();
        fin = 1;
      end
    end
    bus.wdat_v_i = 0; bus.xdat_v_i = 0; bus.mac_v_i = '0; bus.cmd_v_i = 0;
    @(posedge clk_i); #1;
    chk({nm, "_idle_cmd_rdy"}, bus.cmd_rdy_o, 1);
    chk({nm, "_idle_busy"},    bus.busy_o, 0);
    chk({nm, "_done_once"},    bus.done_o, 0);
    chk({nm, "_n_w"},     n_w, reuse ? 0 : NW);
    chk({nm, "_n_x"},     n_x, NX);
    chk({nm, "_n_start"}, n_s, 1);
    chk({nm, "_n_done"},  n_d, 1);
    chk({nm, "_sb_left"}, q.size(), 0);
    if (reuse) chk({nm, "_first_x_lat"}, first_x_cyc - cmd_cyc, 2);
  endtask

  initial begin
    bus.cmd_v_i = 0; bus.wdat_v_i = 0; bus.wdat_i = '0;
    bus.xdat_v_i = 0; bus.xdat_i = '0; bus.mac_v_i = '0;
`ifdef SA_CTRL_WREUSE_EN
    bus.reuse_w_i = 0;
`endif
    #1 rst_n = 1'b0;
    #2;
    chk("reset_cmd_rdy", bus.cmd_rdy_o, 1);
    chk("reset_busy",    bus.busy_o, 0);
    chk("reset_w_en",    bus.w_en_o, 0);
    chk("reset_rbuf",    bus.rbuf_w_vo, 0);
    chk("reset_start",   bus.start_vo, 0);
    chk("reset_done",    bus.done_o, 0);
    #9 rst_n = 1'b1;

    run_job("full",     0, 1, 0, -1, 0);
    run_job("toggle",   1, 0, 0, -1, 0);
    run_job("cmd_in_x", 0, 0, 1, -1, 0);
    run_job("abort",    0, 0, 0, 30, 0);
    run_job("restart",  0, 0, 0, -1, 0);
`ifdef SA_CTRL_WREUSE_EN
    run_job("reuse",    0, 0, 0, -1, 1);
`endif
    repeat (3) @(posedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sa_ctrl.md
SA_CTRL -- requirements
Module: sa_ctrl

Interface
REQ-001 SHALL have parameter ARRAY_W, default 8, PE columns.
REQ-002 SHALL have parameter ARRAY_H, default 8, PE rows.
REQ-003 SHALL have parameter W_W, default 8, weight width.
REQ-004 SHALL have parameter X_W, default 8, activation width.
REQ-005 SHALL have parameter RBUF_DEPTH, default 8, activation slots per row buffer.
REQ-006 SHALL have port clk_i  input  1  single clock, rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port cmd_v_i  input  1  job request.
REQ-009 SHALL have port cmd_rdy_o  output  1  controller idle, job accepted.
REQ-010 SHALL have port wdat_v_i / wdat_rdy_o / wdat_i  in / out / in  1 / 1 / W_W  weight stream.
REQ-011 SHALL have port xdat_v_i / xdat_rdy_o / xdat_i  in / out / in  1 / 1 / X_W  activation stream.
REQ-012 SHALL have port w_o / w_addr_o / w_en_o  output  W_W / clog2(ARRAY_W*ARRAY_H) / 1  array weight write.
REQ-013 SHALL have port rbuf_wdata_o / rbuf_waddr_o / rbuf_w_vo  output  X_W / clog2(ARRAY_H)+clog2(RBUF_DEPTH) / 1  row-buffer write.
REQ-014 SHALL have port start_vo  output  1  array start pulse.
REQ-015 SHALL have port mac_v_i  input  ARRAY_W  per-column result valid from array.
REQ-016 SHALL have port busy_o / done_o  output  1 / 1  job active; job-complete pulse.

Function
REQ-017 SHALL implement FSM IDLE -> LOAD_W -> LOAD_X -> START -> RUN -> DONE -> IDLE.
REQ-018 SHALL assert cmd_rdy_o only in IDLE; cmd_v_i outside IDLE is ignored.
REQ-019 SHALL, in IDLE with cmd_v_i=1, enter LOAD_W next cycle and clear all counters.
REQ-020 SHALL assert wdat_rdy_o only in LOAD_W; beat transfers when wdat_v_i & wdat_rdy_o; wdat_v_i low stalls without side effects.
REQ-021 SHALL register each weight beat: w_en_o=1, w_o=beat, w_addr_o=beat index one cycle after transfer; address upper clog2(ARRAY_W) bits = column, lower clog2(ARRAY_H) bits = row, index 0..ARRAY_W*ARRAY_H-1 in order.
REQ-022 SHALL leave LOAD_W for LOAD_X on the cycle after the last weight beat transfers.
REQ-023 SHALL assert xdat_rdy_o only in LOAD_X; register each beat to rbuf_w_vo/rbuf_wdata_o/rbuf_waddr_o one cycle after transfer; address upper bits = row, lower bits = slot, index 0..ARRAY_H*RBUF_DEPTH-1.
REQ-024 SHALL enter START after the last activation beat and drive start_vo=1 for exactly one cycle, which is also the cycle after the final rbuf write.
REQ-025 SHALL, in RUN, count cycles with |mac_v_i=1 and enter DONE when count reaches RBUF_DEPTH+ARRAY_W-1; mac_v_i outside RUN is ignored.
REQ-026 SHALL pulse done_o one cycle in DONE and return to IDLE; busy_o=1 in every state except IDLE.
REQ-027 SHALL keep w_en_o, rbuf_w_vo, start_vo mutually exclusive; none asserted outside their state.

Reset
REQ-028 SHALL, on rst_n=0 at any time including mid-job, asynchronously enter IDLE with all counters and outputs 0 except cmd_rdy_o=1.
REQ-029 SHALL, after reset release, require a new cmd_v_i; partial loads are not resumed.

Configuration
REQ-030 SHALL, with SA_CTRL_WREUSE_EN defined, add input reuse_w_i (1 bit), sampled with accepted cmd_v_i; reuse_w_i=1 goes IDLE -> LOAD_X, skipping LOAD_W and keeping array weights.
REQ-031 SHALL, without SA_CTRL_WREUSE_EN, omit reuse_w_i and always run LOAD_W.

Verification
REQ-032 SHALL cover: full job, streams always valid, weight 8'h0F -> 64 w_en_o writes addr 0..63, 64 rbuf writes addr 0..63, one start_vo, 15 valid result cycles, then done_o, cmd_rdy_o=1.
REQ-033 SHALL cover: wdat_v_i toggling every other cycle -> exactly 64 w_en_o pulses, contiguous addresses, no duplicates.
REQ-034 SHALL cover: cmd_v_i=1 in LOAD_X -> ignored, counters unchanged, single done_o.
REQ-035 SHALL cover: rst_n=0 after 30 weight beats -> all outputs 0 immediately, cmd_rdy_o=1; next job restarts at w_addr_o=0.
REQ-036 SHALL cover, with SA_CTRL_WREUSE_EN defined: reuse_w_i=1 -> zero w_en_o pulses, first rbuf write 2 cycles after command.
